// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package mem_arb_types;

  localparam int unsigned MEM_ARB_ADDR_W = 32;
  localparam int unsigned MEM_ARB_LINE_W = 256;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  // Requester identity, used for tie-break input and output
  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_sel_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Combinational tie-break between the I-cache and D-cache requests.
// A lone requester always wins; on a tie the port that was not served
// last wins. Feeding i_last = PORT_I permanently gives fixed D priority.
module mem_arb_grant
  import mem_arb_types::*;
(
  input  logic      i_req_i,
  input  logic      i_req_d,
  input  port_sel_e i_last,
  output port_sel_e o_sel
);

  // Pick the winning port from the two request bits and the last-served port
  always_comb begin
    o_sel = PORT_I;
    if (i_req_d && !i_req_i) begin
      o_sel = PORT_D;
    end else if (i_req_d && i_req_i) begin
      o_sel = (i_last == PORT_I) ? PORT_D : PORT_I;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter between the I-cache, the D-cache and the single
// physical memory port. One requester is granted at a time and the grant
// is held until pmem_resp, at which point the FSM returns to IDLE.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN -- when defined, ties
// alternate using a last-served register; otherwise the D-cache always
// wins a tie.
module mem_arbiter
  import mem_arb_types::*;
#(
  parameter int unsigned ADDR_W = MEM_ARB_ADDR_W,
  parameter int unsigned LINE_W = MEM_ARB_LINE_W
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache port
  input  logic              imem_read,
  input  logic              imem_write,
  input  logic [ADDR_W-1:0] imem_address,
  input  logic [LINE_W-1:0] imem_wdata,
  output logic [LINE_W-1:0] imem_rdata,
  output logic              imem_resp,
  // D-cache port
  input  logic              dmem_read,
  input  logic              dmem_write,
  input  logic [ADDR_W-1:0] dmem_address,
  input  logic [LINE_W-1:0] dmem_wdata,
  output logic [LINE_W-1:0] dmem_rdata,
  output logic              dmem_resp,
  // Physical memory port
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_e    r_state;
  port_sel_e w_last;
  port_sel_e w_sel;
  logic      w_req_i;
  logic      w_req_d;

  assign w_req_i = imem_read | imem_write;
  assign w_req_d = dmem_read | dmem_write;

  // Read data is broadcast; only the resp pulse tells a cache it is theirs
  assign imem_rdata = pmem_rdata;
  assign dmem_rdata = pmem_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  port_sel_e r_last;

  // Remember which port completed most recently; starts as I so D wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= PORT_I;
    end else if (pmem_resp) begin
      if (r_state == SERVE_I) begin
        r_last <= PORT_I;
      end else if (r_state == SERVE_D) begin
        r_last <= PORT_D;
      end
    end
  end

  assign w_last = r_last;
`else
  // Pretending I was always served last makes D win every tie
  assign w_last = PORT_I;
`endif

  mem_arb_grant u_grant (
    .i_req_i (w_req_i),
    .i_req_d (w_req_d),
    .i_last  (w_last),
    .o_sel   (w_sel)
  );

  // Grant FSM: arbitrate in IDLE, hold the grant until memory completes
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_req_i || w_req_d) begin
            r_state <= (w_sel == PORT_D) ? SERVE_D : SERVE_I;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Route the granted port to memory and steer pmem_resp back to it only
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    imem_resp    = 1'b0;
    dmem_resp    = 1'b0;
    unique case (r_state)
      SERVE_I: begin
        pmem_read    = imem_read;
        pmem_write   = imem_write;
        pmem_address = imem_address;
        pmem_wdata   = imem_wdata;
        imem_resp    = pmem_resp;
      end
      SERVE_D: begin
        pmem_read    = dmem_read;
        pmem_write   = dmem_write;
        pmem_address = dmem_address;
        pmem_wdata   = dmem_wdata;
        dmem_resp    = pmem_resp;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed cycle table, a continuous
// contention sequence, and randomized traffic against a grant-owner model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam logic [AW-1:0] I_ADDR = 32'h0000_0040;
  localparam logic [AW-1:0] D_ADDR = 32'h0000_1000;
  localparam logic [LW-1:0] I_WD   = {8{32'h1111_2222}};
  localparam logic [LW-1:0] D_WD   = {8{32'h3333_4444}};
  localparam logic [LW-1:0] RD_A5  = {32{8'hA5}};

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_read, imem_write, dmem_read, dmem_write;
  logic [AW-1:0] imem_address, dmem_address;
  logic [LW-1:0] imem_wdata, dmem_wdata;
  logic [LW-1:0] imem_rdata, dmem_rdata;
  logic          imem_resp, dmem_resp;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata, pmem_rdata;
  logic          pmem_resp;

  int n_err = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_write   (imem_write),
    .imem_address (imem_address),
    .imem_wdata   (imem_wdata),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  // sel: 0 = nobody routed, 1 = I routed, 2 = D routed
  typedef struct {
    logic rst, ir, iw, dr, dw, presp;
    logic pr, pw;
    int   sel;
    logic irs, drs;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst_v, ir, iw, dr, dw, presp,
                              input logic pr, pw, input int sel,
                              input logic irs, drs);
    vec_t v;
    v.rst = rst_v; v.ir = ir; v.iw = iw; v.dr = dr; v.dw = dw; v.presp = presp;
    v.pr = pr; v.pw = pw; v.sel = sel; v.irs = irs; v.drs = drs;
    return v;
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_read = 0; imem_write = 0; dmem_read = 0; dmem_write = 0;
    pmem_resp = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // Reference model: who owns the memory port and who completed last
  int m_owner;  // 0 none, 1 I, 2 D
  int m_last;   // 1 I, 2 D

  function automatic int tie_winner(input int last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return (last == 1) ? 2 : 1;
`else
    return 2;
`endif
  endfunction

  int exp_order[4];
  int got;
  int seen;
  logic [AW-1:0] e_addr;
  logic [LW-1:0] e_wd, rd_v;
  logic e_pr, e_pw, e_ir, e_dr, rq_i, rq_d;

  initial begin
    imem_address = I_ADDR; dmem_address = D_ADDR;
    imem_wdata = I_WD; dmem_wdata = D_WD;
    pmem_rdata = RD_A5;
    do_reset();

    // Reset state
    @(negedge clk);
    chk("reset pmem_read", pmem_read, 0);
    chk("reset pmem_write", pmem_write, 0);
    chk("reset pmem_address", pmem_address, 0);
    chk("reset pmem_wdata", pmem_wdata, 0);
    chk("reset imem_resp", imem_resp, 0);
    chk("reset dmem_resp", dmem_resp, 0);
    @(posedge clk); #1;

    //           rst ir iw dr dw rsp | pr pw sel irs drs
    // Single I-read, memory answers on the fifth serve cycle
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // Stray pmem_resp in IDLE
    tbl.push_back(mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // Simultaneous I-read and D-write: D first, then I after one IDLE
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,  0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1,  0, 1, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // D-write in flight, I-read arrives mid-transaction
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0,  0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,  0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0,  0, 1, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1,  0, 1, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // Reset during SERVE_I, then a normal transaction
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // Read and write together on D are both forwarded
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0,  1, 1, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 1,  1, 1, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // D drops its strobe while granted: grant holds until pmem_resp
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0,  1, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,  0, 0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1,  1, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      imem_read = tbl[i].ir; imem_write = tbl[i].iw;
      dmem_read = tbl[i].dr; dmem_write = tbl[i].dw;
      pmem_resp = tbl[i].presp;
      e_addr = (tbl[i].sel == 1) ? I_ADDR : (tbl[i].sel == 2) ? D_ADDR : '0;
      e_wd   = (tbl[i].sel == 1) ? I_WD   : (tbl[i].sel == 2) ? D_WD   : '0;
      @(negedge clk);
      chk($sformatf("vec%0d pmem_read", i), pmem_read, tbl[i].pr);
      chk($sformatf("vec%0d pmem_write", i), pmem_write, tbl[i].pw);
      chk($sformatf("vec%0d pmem_address", i), pmem_address, e_addr);
      chk($sformatf("vec%0d pmem_wdata", i), pmem_wdata, e_wd);
      chk($sformatf("vec%0d imem_resp", i), imem_resp, tbl[i].irs);
      chk($sformatf("vec%0d dmem_resp", i), dmem_resp, tbl[i].drs);
      if (tbl[i].irs) chk($sformatf("vec%0d imem_rdata", i), imem_rdata, RD_A5);
      if (tbl[i].drs) chk($sformatf("vec%0d dmem_rdata", i), dmem_rdata, RD_A5);
      @(posedge clk); #1;
    end

    // Both ports requesting continuously for four transactions
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_order = '{2, 1, 2, 1};
`else
    exp_order = '{2, 2, 2, 2};
`endif
    do_reset();
    imem_read = 1; dmem_read = 1;
    got = 0;
    for (int cyc = 0; cyc < 100 && got < 4; cyc++) begin
      @(negedge clk);
      if (pmem_read) begin
        seen = (pmem_address == D_ADDR) ? 2 : (pmem_address == I_ADDR) ? 1 : 0;
        pmem_resp = 1;
        #1;
        chk($sformatf("contend txn%0d owner", got), seen, exp_order[got]);
        chk($sformatf("contend txn%0d imem_resp", got), imem_resp, exp_order[got] == 1);
        chk($sformatf("contend txn%0d dmem_resp", got), dmem_resp, exp_order[got] == 2);
        $display("contend txn %0d: served %s at addr %h", got,
                 (seen == 2) ? "D" : (seen == 1) ? "I" : "?", pmem_address);
        got++;
      end
      @(posedge clk); #1;
      pmem_resp = 0;
    end
    chk("contend transactions completed", got, 4);
    imem_read = 0; dmem_read = 0;

    // Randomized traffic against the owner model
    do_reset();
    m_owner = 0; m_last = 1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst = ($urandom_range(63) == 0);
      if ($urandom_range(4) == 0) imem_read  = ~imem_read;
      if ($urandom_range(6) == 0) imem_write = ~imem_write;
      if ($urandom_range(4) == 0) dmem_read  = ~dmem_read;
      if ($urandom_range(6) == 0) dmem_write = ~dmem_write;
      imem_address = $urandom(); dmem_address = $urandom();
      imem_wdata = rand_line(); dmem_wdata = rand_line();
      rd_v = rand_line(); pmem_rdata = rd_v;
      pmem_resp = ($urandom_range(3) == 0);
      @(negedge clk);
      e_pr = 0; e_pw = 0; e_addr = '0; e_wd = '0; e_ir = 0; e_dr = 0;
      if (m_owner == 1) begin
        e_pr = imem_read; e_pw = imem_write; e_addr = imem_address;
        e_wd = imem_wdata; e_ir = pmem_resp;
      end else if (m_owner == 2) begin
        e_pr = dmem_read; e_pw = dmem_write; e_addr = dmem_address;
        e_wd = dmem_wdata; e_dr = pmem_resp;
      end
      chk("rand pmem_read", pmem_read, e_pr);
      chk("rand pmem_write", pmem_write, e_pw);
      chk("rand pmem_address", pmem_address, e_addr);
      chk("rand pmem_wdata", pmem_wdata, e_wd);
      chk("rand imem_resp", imem_resp, e_ir);
      chk("rand dmem_resp", dmem_resp, e_dr);
      chk("rand imem_rdata", imem_rdata, rd_v);
      chk("rand dmem_rdata", dmem_rdata, rd_v);
      // Advance the model to the next cycle
      rq_i = imem_read | imem_write;
      rq_d = dmem_read | dmem_write;
      if (rst) begin
        m_owner = 0; m_last = 1;
      end else if (m_owner == 0) begin
        if (rq_i && rq_d) m_owner = tie_winner(m_last);
        else if (rq_d)    m_owner = 2;
        else if (rq_i)    m_owner = 1;
      end else if (pmem_resp) begin
        m_last = m_owner;
        m_owner = 0;
      end
      @(posedge clk); #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter between the split L1 caches (instruction and data) and the single physical memory port. It accepts cache-line read/write requests from the I-cache and D-cache, grants one at a time, routes the granted requester's signals to physical memory, and returns the memory response to that requester only. Requesters use the pipeline's level-sensitive read/write/resp handshake, so each cache's stall term, (read | write) & ~resp, stays valid unchanged.

## Interface
- ADDR_W, 32, byte address width
- LINE_W, 256, cache-line data width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_read / imem_write  in  1  I-cache request strobes, held until imem_resp
- imem_address  in  ADDR_W  I-cache line address
- imem_wdata  in  LINE_W  I-cache write line
- imem_rdata  out  LINE_W  read line (broadcast of pmem_rdata)
- imem_resp  out  1  one-cycle completion pulse to I-cache
- dmem_read / dmem_write / dmem_address / dmem_wdata / dmem_rdata / dmem_resp: same set for the D-cache
- pmem_read / pmem_write  out  1  physical memory strobes
- pmem_address  out  ADDR_W  address to memory
- pmem_wdata  out  LINE_W  write line to memory
- pmem_rdata  in  LINE_W  line from memory
- pmem_resp  in  1  memory completion, valid one cycle

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. Reset → IDLE.
- IDLE: pmem_read/write = 0, pmem_address = 0, pmem_wdata = 0. Any request (read|write) on a port moves to the matching SERVE state next cycle. Both pending → selection per Configuration.
- SERVE_x: pmem_read, pmem_write, pmem_address, pmem_wdata driven combinationally from port x. Other port's resp held 0; its request waits (its stall stays high).
- pmem_resp in SERVE_x: x_resp = 1 that same cycle (combinational); next state IDLE. No other port sees resp.
- imem_rdata and dmem_rdata both equal pmem_rdata at all times; only resp qualifies them.
- Grant holds until pmem_resp, even if the granted requester drops its strobes (protocol violation: pmem strobes then follow the live inputs, FSM still waits for pmem_resp).
- pmem_resp in IDLE is ignored.
- read and write both high on one port: both forwarded; not arbitrated.

## Timing
- Arbitration latency: 1 cycle (request seen in IDLE, pmem strobe asserted in following cycle).
- Completion: x_resp coincides with pmem_resp; FSM is in IDLE the cycle after.
- Back-to-back: a requester still asserting after resp is re-eligible in that IDLE cycle; minimum one IDLE cycle between transactions.
- Reset mid-transaction: FSM → IDLE, priority pointer → D-cache preferred; all resp outputs and pmem strobes 0 the cycle after rst sampled high. Any in-flight memory op is abandoned; memory must be reset with the arbiter.
- All outputs reset values: *_resp = 0, pmem_read = pmem_write = 0, pmem_address = 0, pmem_wdata = 0.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: 1-bit last-served register, updated on each completion; on simultaneous requests in IDLE, the port not served last wins. Reset value: last-served = I, so D wins first.
- Undefined: fixed priority, D-cache always wins a tie; no last-served register. Single-requester behaviour identical in both builds.

## Structure
- Package mem_arb_types: state enum (IDLE, SERVE_I, SERVE_D), port-select enum (PORT_I, PORT_D), default ADDR_W / LINE_W constants.
- One sub-module: mem_arb_grant, combinational tie-break (inputs: two request bits, last-served; output: selected port); pointer register and FSM stay in mem_arbiter.

## Test plan
- Reset then single I-read at 0x0000_0040, memory responds after 5 cycles with 0xA5…A5 → pmem_read rises 1 cycle after request, imem_resp pulses once with imem_rdata = 0xA5…A5, dmem_resp stays 0.
- I-read and D-write (0x0000_1000) asserted same cycle → D served first in both builds; I served after D's resp plus one IDLE cycle; pmem_address sequence 0x1000 then I address.
- Both ports requesting continuously for 4 transactions → with MEM_ARB_ROUND_ROBIN_EN order D,I,D,I; without it D,D,D,D and I starved.
- D-write in flight, new I-read arrives mid-transaction → pmem signals remain D's until pmem_resp; I granted next.
- rst asserted during SERVE_I before pmem_resp → next cycle pmem_read = 0, IDLE, no resp pulse; subsequent request proceeds normally.
- Stray pmem_resp in IDLE → no resp output, FSM stays IDLE.
